// File: rtl/three_phase_phase_gen_if.sv
// Handshake/bus bundle between the NCO phase generator and its controller.
// Latency: none (wires only).
// Backpressure: ftw_ready is owned by the slave (generator); the master holds ftw_valid/ftw_in until accepted.
// Ports (master view): en, sync_clr, ftw_in, ftw_valid -> ; <- ftw_ready, address1..3, addr_valid, wrap.
interface three_phase_phase_gen_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 15
);
    logic              en;
    logic              sync_clr;
    logic [ACC_W-1:0]  ftw_in;
    logic              ftw_valid;
    logic              ftw_ready;
    logic [ADDR_W-1:0] address1;
    logic [ADDR_W-1:0] address2;
    logic [ADDR_W-1:0] address3;
    logic              addr_valid;
    logic              wrap;

    modport master (
        output en, sync_clr, ftw_in, ftw_valid,
        input  ftw_ready, address1, address2, address3, addr_valid, wrap
    );

    modport slave (
        input  en, sync_clr, ftw_in, ftw_valid,
        output ftw_ready, address1, address2, address3, addr_valid, wrap
    );
endinterface

// File: rtl/three_phase_phase_gen.sv
// Three-phase phase-accumulator NCO producing LUT addresses at 0/120/240 degrees.
// Latency: addresses reflect the accumulator value before the enabling edge, registered 1 cycle.
// Backpressure: one FTW held at a time; ftw_ready low while an FTW waits for its apply point.
// Ports: clk, reset (async active-high), bus (slave modport: en, sync_clr, ftw_in/valid/ready,
//        address1..3, addr_valid, wrap).
module three_phase_phase_gen #(
    parameter int              ACC_W          = 32,
    parameter int              ADDR_W         = 15,
    parameter logic [ACC_W-1:0] DEF_FTW       = 32'h0002_0000,
    parameter int              UPDATE_AT_WRAP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    three_phase_phase_gen_if.slave  bus
);

    // Phase offsets for 120 and 240 degrees (one third / two thirds of 2^32).
    localparam logic [ACC_W-1:0] OFF_2 = ACC_W'(32'h5555_5555);
    localparam logic [ACC_W-1:0] OFF_3 = ACC_W'(32'hAAAA_AAAA);
    // Address values corresponding to acc == 0.
    localparam logic [ADDR_W-1:0] RST_A1 = '0;
    localparam logic [ADDR_W-1:0] RST_A2 = OFF_2[ACC_W-1 -: ADDR_W];
    localparam logic [ADDR_W-1:0] RST_A3 = OFF_3[ACC_W-1 -: ADDR_W];

    typedef enum logic {IDLE, PENDING} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  ftw_active;
    logic [ACC_W-1:0]  ftw_shadow;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic              capture;
    logic              apply;
    logic [ACC_W-1:0]  phase2;
    logic [ACC_W-1:0]  phase3;
    logic [ADDR_W-1:0] address1_q;
    logic [ADDR_W-1:0] address2_q;
    logic [ADDR_W-1:0] address3_q;
    logic              addr_valid_q;
    logic              wrap_q;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, ftw_active};
        carry  = sum[ACC_W];
        phase2 = acc + OFF_2;
        phase3 = acc + OFF_3;
    end

    // FTW handshake: capture in IDLE, apply from PENDING. With UPDATE_AT_WRAP
    // the apply waits for a carry, except when ftw_active is zero, where no
    // carry can ever happen and waiting would deadlock.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ftw_valid) begin
                    capture   = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (bus.sync_clr) begin
                    apply = 1'b1;
                end else if (bus.en &&
                             ((UPDATE_AT_WRAP == 0) || carry || (ftw_active == '0))) begin
                    apply = 1'b1;
                end
                if (apply) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ftw_active <= DEF_FTW;
            ftw_shadow <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                ftw_shadow <= bus.ftw_in;
            end
            // The carry that triggers a wrap apply was produced with the old
            // FTW; the new one takes effect from the following step.
            if (apply) begin
                ftw_active <= ftw_shadow;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            address1_q   <= RST_A1;
            address2_q   <= RST_A2;
            address3_q   <= RST_A3;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else if (bus.sync_clr) begin
            acc          <= '0;
            address1_q   <= RST_A1;
            address2_q   <= RST_A2;
            address3_q   <= RST_A3;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else if (bus.en) begin
            acc          <= sum[ACC_W-1:0];
            address1_q   <= acc[ACC_W-1 -: ADDR_W];
            address2_q   <= phase2[ACC_W-1 -: ADDR_W];
            address3_q   <= phase3[ACC_W-1 -: ADDR_W];
            addr_valid_q <= 1'b1;
            wrap_q       <= carry;
        end else begin
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end
    end

    // Ready comes straight from the state flop, so it rises on the edge after an apply.
    assign bus.ftw_ready  = (state == IDLE);
    assign bus.address1   = address1_q;
    assign bus.address2   = address2_q;
    assign bus.address3   = address3_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.wrap       = wrap_q;

endmodule
